// File: rtl/tl_ul_mem.sv
// TL-UL single-beat memory slave, one transaction outstanding.
// Byte array `memory` is left untouched by reset so preloads survive.
module tl_ul_mem #(
    parameter int XLEN      = 32,
    parameter int SID_WIDTH = 2,
    parameter int SIZE      = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tl_a_valid,
    output logic                 tl_a_ready,
    input  logic [2:0]           tl_a_opcode,
    input  logic [2:0]           tl_a_param,
    input  logic [2:0]           tl_a_size,
    input  logic [SID_WIDTH-1:0] tl_a_source,
    input  logic [XLEN-1:0]      tl_a_address,
    input  logic [XLEN/8-1:0]    tl_a_mask,
    input  logic [XLEN-1:0]      tl_a_data,
    output logic                 tl_d_valid,
    input  logic                 tl_d_ready,
    output logic [2:0]           tl_d_opcode,
    output logic [1:0]           tl_d_param,
    output logic [2:0]           tl_d_size,
    output logic [SID_WIDTH-1:0] tl_d_source,
    output logic [XLEN-1:0]      tl_d_data,
    output logic                 tl_d_corrupt,
    output logic                 tl_d_denied
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int AW = $clog2(SIZE + 1);

    typedef enum logic {IDLE, RESP} state_e;

    logic [7:0] memory [0:SIZE];

    state_e                 state_q;
    logic                   d_valid_q;
    logic [2:0]             d_opcode_q;
    logic [2:0]             d_size_q;
    logic [SID_WIDTH-1:0]   d_source_q;
    logic [XLEN-1:0]        d_data_q;
    logic                   d_denied_q;

    logic                   accept;
    logic                   op_get;
    logic                   op_put;
    logic                   size_ok;
    logic                   align_ok;
    logic                   range_ok;
    logic                   deny;
    logic [XLEN-1:0]        size_bytes;
    logic [XLEN-1:0]        base;
    logic [XLEN:0]          last;
    logic [XLEN-1:0]        rdata;
    logic                   unused_param;

    assign unused_param = ^tl_a_param;

    assign tl_a_ready = (state_q == IDLE) && reset;
    assign accept     = tl_a_valid && tl_a_ready;

    assign op_get     = (tl_a_opcode == 3'd4);
    assign op_put     = (tl_a_opcode == 3'd0) || (tl_a_opcode == 3'd1);
    assign size_ok    = (tl_a_size <= 3'(OW));
    assign size_bytes = XLEN'(1) << tl_a_size;
    assign align_ok   = ((tl_a_address & (size_bytes - XLEN'(1))) == '0);
    // Widened by one bit so the end-address sum cannot wrap.
    assign last       = {1'b0, tl_a_address} + {1'b0, size_bytes}
                        - (XLEN+1)'(1);
    assign range_ok   = (last <= (XLEN+1)'(SIZE));
    assign deny       = !(op_get || op_put) || !size_ok
                        || !align_ok || !range_ok;
    assign base       = tl_a_address & ~XLEN'(NB - 1);

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NB; i++) begin
            rdata[8*i +: 8] = memory[AW'(base + XLEN'(i))];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && op_put && !deny) begin
            for (int i = 0; i < NB; i++) begin
                if (tl_a_mask[i]) begin
                    memory[AW'(base + XLEN'(i))] <= tl_a_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_denied_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= RESP;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= op_get ? 3'd1 : 3'd0;
                        d_size_q   <= tl_a_size;
                        d_source_q <= tl_a_source;
                        d_data_q   <= (op_get && !deny) ? rdata : '0;
                        d_denied_q <= deny;
                    end
                end
                RESP: begin
                    if (tl_d_ready) begin
                        state_q   <= IDLE;
                        d_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tl_d_valid   = d_valid_q;
    assign tl_d_opcode  = d_opcode_q;
    assign tl_d_param   = 2'b00;
    assign tl_d_size    = d_size_q;
    assign tl_d_source  = d_source_q;
    assign tl_d_data    = d_data_q;
    assign tl_d_corrupt = 1'b0;
    assign tl_d_denied  = d_denied_q;

endmodule

// File: tb/tb_tl_ul_mem.sv
// Directed bench for tl_ul_mem: scoreboard of expected D beats
// built from a byte-array reference model.
module tb_tl_ul_mem;

    logic        clk;
    logic        reset;
    logic        tl_a_valid;
    logic        tl_a_ready;
    logic [2:0]  tl_a_opcode;
    logic [2:0]  tl_a_param;
    logic [2:0]  tl_a_size;
    logic [1:0]  tl_a_source;
    logic [31:0] tl_a_address;
    logic [3:0]  tl_a_mask;
    logic [31:0] tl_a_data;
    logic        tl_d_valid;
    logic        tl_d_ready;
    logic [2:0]  tl_d_opcode;
    logic [1:0]  tl_d_param;
    logic [2:0]  tl_d_size;
    logic [1:0]  tl_d_source;
    logic [31:0] tl_d_data;
    logic        tl_d_corrupt;
    logic        tl_d_denied;

    tl_ul_mem dut (
        .clk          (clk),
        .reset        (reset),
        .tl_a_valid   (tl_a_valid),
        .tl_a_ready   (tl_a_ready),
        .tl_a_opcode  (tl_a_opcode),
        .tl_a_param   (tl_a_param),
        .tl_a_size    (tl_a_size),
        .tl_a_source  (tl_a_source),
        .tl_a_address (tl_a_address),
        .tl_a_mask    (tl_a_mask),
        .tl_a_data    (tl_a_data),
        .tl_d_valid   (tl_d_valid),
        .tl_d_ready   (tl_d_ready),
        .tl_d_opcode  (tl_d_opcode),
        .tl_d_param   (tl_d_param),
        .tl_d_size    (tl_d_size),
        .tl_d_source  (tl_d_source),
        .tl_d_data    (tl_d_data),
        .tl_d_corrupt (tl_d_corrupt),
        .tl_d_denied  (tl_d_denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic        den;
        logic [1:0]  src;
        logic [2:0]  sz;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [0:65535];
    int         vecs = 0;
    int         errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] addr,
                       input logic [2:0] sz, input logic [3:0] m,
                       input logic [31:0] d, input logic [1:0] src);
        exp_t   e;
        int     nb;
        longint la;
        int     n;
        logic [31:0] b;
        nb = 1 << sz;
        la = longint'(addr);
        b  = addr & 32'hFFFF_FFFC;
        e.den = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || nb > 4
                || (la % nb) != 0 || la + nb - 1 > 65535;
        e.op  = (op == 3'd4) ? 3'd1 : 3'd0;
        e.src = src;
        e.sz  = sz;
        e.data = '0;
        if (!e.den && op == 3'd4)
            e.data = {model[b+3], model[b+2], model[b+1], model[b]};
        if (!e.den && op != 3'd4)
            for (int i = 0; i < 4; i++)
                if (m[i]) model[b+i] = d[8*i +: 8];
        tl_a_valid   = 1'b1;
        tl_a_opcode  = op;
        tl_a_param   = 3'd5;
        tl_a_size    = sz;
        tl_a_source  = src;
        tl_a_address = addr;
        tl_a_mask    = m;
        tl_a_data    = d;
        n = 0;
        while (!tl_a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tl_a_ready) chk("a_ready_timeout", 0, 1);
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        tl_a_valid = 1'b0;
    endtask

    task automatic resp(input string tag, input int hold);
        exp_t e;
        logic [31:0] d0;
        chk({tag, "_latency"}, tl_d_valid, 1);
        d0 = tl_d_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(tl_d_valid && tl_d_data === d0 && !tl_a_ready))
                chk({tag, "_stall"}, {tl_d_valid, tl_a_ready, tl_d_data},
                    {1'b1, 1'b0, d0});
        end
        if (hold > 0) chk({tag, "_stall_a_ready"}, tl_a_ready, 0);
        e = sb.pop_front();
        chk({tag, "_opcode"},  tl_d_opcode,  e.op);
        chk({tag, "_data"},    tl_d_data,    e.data);
        chk({tag, "_denied"},  tl_d_denied,  e.den);
        chk({tag, "_source"},  tl_d_source,  e.src);
        chk({tag, "_size"},    tl_d_size,    e.sz);
        chk({tag, "_param"},   {tl_d_param, tl_d_corrupt}, 0);
        tl_d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tl_d_ready = 1'b0;
        chk({tag, "_ready_back"}, {tl_a_ready, tl_d_valid}, 2'b10);
    endtask

    task automatic mem_chk(input string tag, input int a0, input int a1);
        for (int a = a0; a <= a1; a++)
            chk(tag, dut.memory[a], model[a]);
    endtask

    initial begin
        reset = 1'b0;
        tl_a_valid = 1'b0; tl_a_opcode = '0; tl_a_param = '0;
        tl_a_size = '0; tl_a_source = '0; tl_a_address = '0;
        tl_a_mask = '0; tl_a_data = '0; tl_d_ready = 1'b0;
        for (int i = 0; i < 65536; i++) model[i] = 8'h00;
        model[0] = 8'h13; model[1] = 8'h05;
        model[16'hFFFC] = 8'h44; model[16'hFFFD] = 8'h33;
        model[16'hFFFE] = 8'h22; model[16'hFFFF] = 8'h11;
        for (int i = 0; i < 65536; i++) dut.memory[i] = model[i];
        repeat (3) @(negedge clk);
        chk("rst_state", {tl_a_ready, tl_d_valid, tl_d_opcode,
                          tl_d_data, tl_d_denied}, 0);
        reset = 1'b1;
        #1;
        chk("rst_rel_a_ready", tl_a_ready, 1);
        @(negedge clk);

        req(3'd4, 32'h0, 3'd2, 4'hF, 32'h0, 2'd1);
        resp("get0", 0);
        chk("get0_const", tl_d_data, 32'h0000_0513);

        req(3'd0, 32'hFF00, 3'd2, 4'hF, 32'hDEADBEEF, 2'd2);
        resp("putfull", 0);
        mem_chk("putfull_mem", 16'hFF00, 16'hFF03);
        req(3'd4, 32'hFF00, 3'd2, 4'hF, 32'h0, 2'd3);
        resp("get_ff00", 0);

        req(3'd1, 32'hFF05, 3'd0, 4'b0010, 32'h0000_AA00, 2'd0);
        resp("putpart", 0);
        req(3'd4, 32'hFF04, 3'd2, 4'hF, 32'h0, 2'd1);
        resp("get_ff04", 5);

        req(3'd4, 32'h1_0000, 3'd2, 4'hF, 32'h0, 2'd2);
        resp("deny_range", 0);
        req(3'd4, 32'h2, 3'd2, 4'hF, 32'h0, 2'd3);
        resp("deny_align", 0);
        req(3'd6, 32'h0, 3'd2, 4'hF, 32'h0, 2'd0);
        resp("deny_opc", 0);
        req(3'd4, 32'h0, 3'd3, 4'hF, 32'h0, 2'd1);
        resp("deny_size", 0);
        req(3'd0, 32'hFF02, 3'd2, 4'hF, 32'h12345678, 2'd2);
        resp("deny_put", 0);
        req(3'd0, 32'hFFFE, 3'd2, 4'hF, 32'h12345678, 2'd3);
        resp("deny_put_end", 0);
        mem_chk("deny_mem", 16'hFF00, 16'hFF07);
        mem_chk("deny_mem_end", 16'hFFFC, 16'hFFFF);

        req(3'd4, 32'hFFFC, 3'd2, 4'hF, 32'h0, 2'd0);
        resp("get_top", 0);
        req(3'd4, 32'hFFFE, 3'd1, 4'h3, 32'h0, 2'd1);
        resp("get_top_half", 0);
        req(3'd1, 32'hFFFF, 3'd0, 4'b1000, 32'h5A00_0000, 2'd2);
        resp("put_last", 0);
        req(3'd4, 32'hFFFC, 3'd2, 4'hF, 32'h0, 2'd3);
        resp("get_top2", 0);

        req(3'd4, 32'hFF00, 3'd2, 4'hF, 32'h0, 2'd1);
        chk("midrst_valid_pre", tl_d_valid, 1);
        reset = 1'b0;
        #1;
        chk("midrst_drop", {tl_d_valid, tl_a_ready}, 0);
        void'(sb.pop_front());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_chk("midrst_mem", 16'hFF00, 16'hFF07);
        req(3'd4, 32'hFF04, 3'd2, 4'hF, 32'h0, 2'd2);
        resp("post_rst_get", 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
